// File: rtl/cache_pkg.sv
// Shared types for the cache subsystem: response codes seen by cache_ctrl
// and the responder's state encoding.
package cache_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    HM_NONE = 2'd0,
    HM_HIT  = 2'd1,
    HM_MISS = 2'd2
  } hit_or_miss_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOOKUP  = 2'd1,
    ST_RESPOND = 2'd2,
    ST_FILL    = 2'd3
  } resp_state_e;

endpackage

// File: rtl/cache_tag_store.sv
// Direct-mapped tag/data store: combinational read by index, one write port,
// single-cycle invalidate of every line.
module cache_tag_store #(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               line_valid,
  output logic [TAG_W-1:0]   line_tag,
  output logic [DATA_W-1:0]  line_data,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               flush
);

  localparam int LINES = 2 ** INDEX_W;

  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else if (we) begin
      valid_d[wr_idx] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // NOTE: tag/data arrays are deliberately not reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign line_valid = valid_q[rd_idx];
  assign line_tag   = tag_q[rd_idx];
  assign line_data  = data_q[rd_idx];

endmodule

// File: rtl/cache_tag_responder.sv
// Cache-side responder: answers lookups with HIT/MISS after LOOKUP_LAT cycles,
// serves reads on hit and fills from memory on miss over a req/ack handshake.
module cache_tag_responder
  import cache_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int INDEX_W    = 3,
  parameter int LOOKUP_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              check_cache,
  input  logic              read_cache,
  input  logic              read_memory,
  input  logic              flush,
  output logic [1:0]        hit_or_miss,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic              proto_err
);

  localparam int TAG_W = ADDR_W - INDEX_W;

  resp_state_e       state_q, state_d;
  hit_or_miss_e      hm_q, hm_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        lat_q, lat_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              proto_err_q, proto_err_d;
  logic              flush_pend_q, flush_pend_d;

  logic              st_we, st_flush;
  logic              line_valid;
  logic [TAG_W-1:0]  line_tag;
  logic [DATA_W-1:0] line_data;
  logic              hit_now;

  cache_tag_store #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx     (addr_q[INDEX_W-1:0]),
    .line_valid (line_valid),
    .line_tag   (line_tag),
    .line_data  (line_data),
    .we         (st_we),
    .wr_idx     (addr_q[INDEX_W-1:0]),
    .wr_tag     (addr_q[ADDR_W-1:INDEX_W]),
    .wr_data    (mem_data),
    .flush      (st_flush)
  );

  assign hit_now = line_valid && (line_tag == addr_q[ADDR_W-1:INDEX_W]);

  always_comb begin
    state_d      = state_q;
    hm_d         = hm_q;
    addr_d       = addr_q;
    lat_d        = lat_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    proto_err_d  = proto_err_q;
    flush_pend_d = flush_pend_q;
    st_we        = 1'b0;
    st_flush     = 1'b0;

    // Flushes seen while busy are remembered and applied on the next idle cycle.
    if (state_q != ST_IDLE && flush) flush_pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        hm_d = HM_NONE;
        if (check_cache) begin
          addr_d  = address;
          lat_d   = 3'(LOOKUP_LAT - 1);
          state_d = ST_LOOKUP;
          if (flush) flush_pend_d = 1'b1;
        end else if (flush || flush_pend_q) begin
          st_flush     = 1'b1;
          flush_pend_d = 1'b0;
        end
      end
      ST_LOOKUP: begin
        if (lat_q == 3'd0) begin
          hm_d    = hit_now ? HM_HIT : HM_MISS;
          state_d = ST_RESPOND;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      ST_RESPOND: begin
        if ((read_cache && read_memory) ||
            (read_cache && hm_q != HM_HIT) ||
            (read_memory && hm_q != HM_MISS)) begin
          proto_err_d = 1'b1;
          hm_d        = HM_NONE;
          state_d     = ST_IDLE;
        end else if (read_cache) begin
          rd_data_d  = line_data;
          rd_valid_d = 1'b1;
          hm_d       = HM_NONE;
          state_d    = ST_IDLE;
        end else if (read_memory) begin
          mem_req_d  = 1'b1;
          mem_addr_d = addr_q;
          hm_d       = HM_NONE;
          state_d    = ST_FILL;
        end else if (!check_cache) begin
          hm_d    = HM_NONE;
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (mem_ack) begin
          st_we      = 1'b1;
          mem_req_d  = 1'b0;
          rd_data_d  = mem_data;
          rd_valid_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hm_q         <= HM_NONE;
      addr_q       <= '0;
      lat_q        <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      proto_err_q  <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hm_q         <= hm_d;
      addr_q       <= addr_d;
      lat_q        <= lat_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      proto_err_q  <= proto_err_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign hit_or_miss = hm_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_cache_tag_responder.sv
// Directed bench: a LOOKUP_LAT=1 responder for the main flows and a
// LOOKUP_LAT=4 responder for latency and deferred flush; sel picks the active one.
module tb_cache_tag_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic [7:0] address, mem_data;
  logic       check_cache, read_cache, read_memory, flush, mem_ack;

  logic [1:0] hm1, hm4;
  logic [7:0] rdd1, rdd4, maddr1, maddr4;
  logic       rdv1, rdv4, mreq1, mreq4, perr1, perr4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_tag_responder #(.LOOKUP_LAT(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .address     (address),
    .check_cache (check_cache & ~sel),
    .read_cache  (read_cache  & ~sel),
    .read_memory (read_memory & ~sel),
    .flush       (flush       & ~sel),
    .hit_or_miss (hm1),
    .rd_data     (rdd1),
    .rd_valid    (rdv1),
    .mem_req     (mreq1),
    .mem_addr    (maddr1),
    .mem_ack     (mem_ack & ~sel),
    .mem_data    (mem_data),
    .proto_err   (perr1)
  );

  cache_tag_responder #(.LOOKUP_LAT(4)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .address     (address),
    .check_cache (check_cache & sel),
    .read_cache  (read_cache  & sel),
    .read_memory (read_memory & sel),
    .flush       (flush       & sel),
    .hit_or_miss (hm4),
    .rd_data     (rdd4),
    .rd_valid    (rdv4),
    .mem_req     (mreq4),
    .mem_addr    (maddr4),
    .mem_ack     (mem_ack & sel),
    .mem_data    (mem_data),
    .proto_err   (perr4)
  );

  logic [1:0] hm;
  logic [7:0] rdd, maddr;
  logic       rdv, mreq, perr;
  assign hm    = sel ? hm4    : hm1;
  assign rdd   = sel ? rdd4   : rdd1;
  assign rdv   = sel ? rdv4   : rdv1;
  assign mreq  = sel ? mreq4  : mreq1;
  assign maddr = sel ? maddr4 : maddr1;
  assign perr  = sel ? perr4  : perr1;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0;
    address = '0; mem_data = '0;
    check_cache = 0; read_cache = 0; read_memory = 0; flush = 0; mem_ack = 0;
    #12;
    check("rst_hm",     32'(hm1),    32'd0);
    check("rst_rdv",    32'(rdv1),   32'd0);
    check("rst_rdd",    32'(rdd1),   32'd0);
    check("rst_mreq",   32'(mreq1),  32'd0);
    check("rst_maddr",  32'(maddr1), 32'd0);
    check("rst_perr",   32'(perr1),  32'd0);
    check("rst_hm4",    32'(hm4),    32'd0);
    rst_n = 1'b1;

    // Cold miss then fill of 0x2A with 0x5C, ack three cycles after mem_req.
    address = 8'h2A; check_cache = 1;
    tick();
    check("cold_lookup_hm", 32'(hm), 32'd0);
    tick();
    check("cold_miss_hm", 32'(hm), 32'd2);
    check_cache = 0; read_memory = 1;
    tick();
    read_memory = 0;
    check("cold_mreq",  32'(mreq),  32'd1);
    check("cold_maddr", 32'(maddr), 32'h2A);
    check("cold_hm0",   32'(hm),    32'd0);
    tick();
    tick();
    check("cold_mreq_hold", 32'(mreq), 32'd1);
    mem_ack = 1; mem_data = 8'h5C;
    tick();
    mem_ack = 0; mem_data = 8'h00;
    check("cold_rdv",     32'(rdv),  32'd1);
    check("cold_rdd",     32'(rdd),  32'h5C);
    check("cold_mreq_lo", 32'(mreq), 32'd0);
    tick();
    check("cold_rdv_pulse", 32'(rdv), 32'd0);
    check("cold_hm_none",   32'(hm),  32'd0);

    // Warm hit on 0x2A.
    check_cache = 1;
    tick();
    tick();
    check("warm_hit_hm", 32'(hm), 32'd1);
    check_cache = 0; read_cache = 1;
    tick();
    read_cache = 0;
    check("warm_rdv",  32'(rdv),  32'd1);
    check("warm_rdd",  32'(rdd),  32'h5C);
    check("warm_mreq", 32'(mreq), 32'd0);
    check("warm_hm0",  32'(hm),   32'd0);
    tick();
    check("warm_rdv_pulse", 32'(rdv), 32'd0);

    // Conflict: 0x4A shares index 2; filling it evicts 0x2A.
    address = 8'h4A; check_cache = 1;
    tick();
    tick();
    check("conf_miss_hm", 32'(hm), 32'd2);
    check_cache = 0; read_memory = 1;
    tick();
    read_memory = 0; mem_ack = 1; mem_data = 8'h11;
    check("conf_maddr", 32'(maddr), 32'h4A);
    tick();
    mem_ack = 0;
    check("conf_fill_rdd", 32'(rdd), 32'h11);
    address = 8'h2A; check_cache = 1;
    tick();
    tick();
    check("conf_evicted_hm", 32'(hm), 32'd2);
    // Abandon: drop check_cache with no read.
    check_cache = 0;
    tick();
    check("abandon_hm0", 32'(hm),  32'd0);
    check("abandon_rdv", 32'(rdv), 32'd0);

    // Protocol error: read_memory on a hit of 0x4A.
    address = 8'h4A; check_cache = 1;
    tick();
    tick();
    check("perr_hit_hm", 32'(hm), 32'd1);
    check_cache = 0; read_memory = 1;
    tick();
    read_memory = 0;
    check("perr_set",  32'(perr), 32'd1);
    check("perr_hm0",  32'(hm),   32'd0);
    check("perr_mreq", 32'(mreq), 32'd0);
    tick();
    tick();
    check("perr_sticky", 32'(perr), 32'd1);
    check("perr_no_mreq", 32'(mreq), 32'd0);

    // Reset mid-fill on 0x2A, then 0x4A must miss (valid bits cleared).
    address = 8'h2A; check_cache = 1;
    tick();
    tick();
    check_cache = 0; read_memory = 1;
    tick();
    read_memory = 0;
    check("rstfill_mreq", 32'(mreq), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstfill_async_mreq", 32'(mreq),  32'd0);
    check("rstfill_async_perr", 32'(perr),  32'd0);
    check("rstfill_async_addr", 32'(maddr), 32'd0);
    #1 rst_n = 1'b1;
    address = 8'h4A; check_cache = 1;
    tick();
    tick();
    check("rstfill_4a_miss", 32'(hm), 32'd2);
    check_cache = 0;
    tick();
    address = 8'h2A; check_cache = 1;
    tick();
    tick();
    check("rstfill_2a_miss", 32'(hm), 32'd2);
    check_cache = 0;
    tick();

    // LOOKUP_LAT=4 instance: fill 0x2A with 0x77 first.
    sel = 1'b1;
    address = 8'h2A; check_cache = 1;
    tick();
    check_cache = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lat4_cold_wait", 32'(hm), 32'd0);
    end
    tick();
    check("lat4_cold_miss", 32'(hm), 32'd2);
    read_memory = 1;
    tick();
    read_memory = 0; mem_ack = 1; mem_data = 8'h77;
    tick();
    mem_ack = 0;
    check("lat4_fill_rdd", 32'(rdd), 32'h77);
    // Hit after exactly four cycles, flush during RESPOND, served read still returns data.
    check_cache = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lat4_hit_wait", 32'(hm), 32'd0);
    end
    tick();
    check("lat4_hit", 32'(hm), 32'd1);
    flush = 1;
    tick();
    flush = 0;
    check("lat4_hold_hit", 32'(hm), 32'd1);
    check_cache = 0; read_cache = 1;
    tick();
    read_cache = 0;
    check("lat4_read_rdv", 32'(rdv), 32'd1);
    check("lat4_read_rdd", 32'(rdd), 32'h77);
    tick();
    check_cache = 1;
    tick();
    check_cache = 0;
    tick();
    tick();
    tick();
    tick();
    check("lat4_flushed_miss", 32'(hm), 32'd2);
    tick();
    check("lat4_abandon_hm0", 32'(hm), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
